// File: rtl/if_stage_if.sv
// Instruction-bus bundle between the fetch stage (master) and instruction memory (slave).
// The request holds, with a stable address, until the cycle that carries the ack.
interface if_stage_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;

  modport master (output ibus_req, output ibus_addr, input ibus_ack, input ibus_rdata);
  modport slave  (input ibus_req, input ibus_addr, output ibus_ack, output ibus_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and presents
// {pc, word, valid, adel} to decode, with stall hold buffer, redirect and misaligned-PC trap.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  if_stage_if.master       ibus,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      inst_code,
  output logic             if_exc_adel
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_HALT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        req_q, req_d;
  // Being in HOLD is what marks the hold buffer as full.
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        valid_q, valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_adel_q, out_adel_d;

  logic slot_free;
  logic ack_v;

  assign slot_free = !valid_q || !stall;
  assign ack_v     = req_q && ibus.ibus_ack;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    hold_pc_d    = hold_pc_q;
    hold_data_d  = hold_data_q;
    valid_d      = valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_adel_d   = out_adel_q;

    if (slot_free) begin
      valid_d = 1'b0;
    end

    if (redirect_en) begin
      valid_d = 1'b0;
      // An unanswered request must still complete on the bus, so its data is discarded later.
      if (req_q && !ibus.ibus_ack) begin
        pending_pc_d = redirect_pc;
        state_d      = S_DISCARD;
      end else begin
        pc_d    = redirect_pc;
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (pc_q[1:0] == 2'b00) begin
            if (ack_v) begin
              pc_d = pc_q + 32'd4;
              if (slot_free) begin
                valid_d    = 1'b1;
                out_pc_d   = pc_q;
                out_inst_d = ibus.ibus_rdata;
                out_adel_d = 1'b0;
              end else begin
                hold_pc_d   = pc_q;
                hold_data_d = ibus.ibus_rdata;
                state_d     = S_HOLD;
              end
            end
          end else if (slot_free) begin
            valid_d    = 1'b1;
            out_pc_d   = pc_q;
            out_inst_d = 32'd0;
            out_adel_d = 1'b1;
            state_d    = S_HALT;
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            valid_d    = 1'b1;
            out_pc_d   = hold_pc_q;
            out_inst_d = hold_data_q;
            out_adel_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_HALT: begin
        end
        S_DISCARD: begin
          if (ack_v) begin
            pc_d    = pending_pc_q;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    req_d = (state_d == S_DISCARD) || ((state_d == S_REQ) && (pc_d[1:0] == 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'd0;
      req_q        <= 1'b0;
      hold_pc_q    <= 32'd0;
      hold_data_q  <= 32'd0;
      valid_q      <= 1'b0;
      out_pc_q     <= 32'd0;
      out_inst_q   <= 32'd0;
      out_adel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      req_q        <= req_d;
      hold_pc_q    <= hold_pc_d;
      hold_data_q  <= hold_data_d;
      valid_q      <= valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_adel_q   <= out_adel_d;
    end
  end

  assign ibus.ibus_req  = req_q;
  assign ibus.ibus_addr = pc_q;
  assign if_valid       = valid_q;
  assign if_pc          = out_pc_q;
  assign inst_code      = out_inst_q;
  assign if_exc_adel    = out_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: drives the instruction bus cycle by cycle and checks
// the decode-side slot and bus request against hand-computed values.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst_code;
  logic        if_exc_adel;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  if_stage_if ibus_if ();

  if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ibus        (ibus_if.master),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .inst_code   (inst_code),
    .if_exc_adel (if_exc_adel)
  );

  function automatic logic [65:0] out_vec();
    return {if_valid, if_exc_adel, if_pc, inst_code};
  endfunction

  function automatic logic [32:0] bus_vec();
    return {ibus_if.ibus_req, ibus_if.ibus_addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata);
    ibus_if.ibus_ack   = ack;
    ibus_if.ibus_rdata = rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;
    drive(1'b0, 32'd0);
    step(); step();
    tests_run++;
    if (out_vec() !== 66'd0) begin
      tests_failed++; $display("FAIL reset_out got %h exp %h", out_vec(), 66'd0);
    end
    tests_run++;
    if (bus_vec() !== {1'b0, 32'hBFC0_0000}) begin
      tests_failed++; $display("FAIL reset_bus got %h exp %h", bus_vec(), {1'b0, 32'hBFC0_0000});
    end
    rst_n = 1'b1;
    step();
    $display("[TB] test_reset done");
  endtask

  task automatic test_zero_wait();
    tests_run++;
    if (bus_vec() !== {1'b1, 32'hBFC0_0000} || if_valid !== 1'b0) begin
      tests_failed++; $display("FAIL zw_first_req got %h v=%b exp %h v=0", bus_vec(), if_valid, {1'b1, 32'hBFC0_0000});
    end
    drive(1'b1, 32'h2408_0001);
    step();
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_0000, 32'h2408_0001} || bus_vec() !== {1'b1, 32'hBFC0_0004}) begin
      tests_failed++; $display("FAIL zw_word0 got %h bus %h exp %h bus %h", out_vec(), bus_vec(),
                               {1'b1, 1'b0, 32'hBFC0_0000, 32'h2408_0001}, {1'b1, 32'hBFC0_0004});
    end
    drive(1'b1, 32'h2409_0002);
    step();
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_0004, 32'h2409_0002}) begin
      tests_failed++; $display("FAIL zw_word1 got %h exp %h", out_vec(), {1'b1, 1'b0, 32'hBFC0_0004, 32'h2409_0002});
    end
    drive(1'b0, 32'd0);
    step();
    tests_run++;
    if (if_valid !== 1'b0 || bus_vec() !== {1'b1, 32'hBFC0_0008}) begin
      tests_failed++; $display("FAIL zw_drain got v=%b bus %h exp v=0 bus %h", if_valid, bus_vec(), {1'b1, 32'hBFC0_0008});
    end
    $display("[TB] test_zero_wait done");
  endtask

  task automatic test_ack_delay();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus_vec() !== {1'b1, 32'hBFC0_0008} || if_valid !== 1'b0) begin
        tests_failed++; $display("FAIL delay_wait%0d got bus %h v=%b exp bus %h v=0", i, bus_vec(), if_valid, {1'b1, 32'hBFC0_0008});
      end
      if (i == 2) drive(1'b1, 32'h3C01_0008);
      step();
    end
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_0008, 32'h3C01_0008} || bus_vec() !== {1'b1, 32'hBFC0_000C}) begin
      tests_failed++; $display("FAIL delay_word got %h bus %h exp %h bus %h", out_vec(), bus_vec(),
                               {1'b1, 1'b0, 32'hBFC0_0008, 32'h3C01_0008}, {1'b1, 32'hBFC0_000C});
    end
    $display("[TB] test_ack_delay done");
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    drive(1'b1, 32'hAAAA_000C);
    step();
    drive(1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall = 1'b0;
      tests_run++;
      if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_0008, 32'h3C01_0008} || ibus_if.ibus_req !== 1'b0) begin
        tests_failed++; $display("FAIL stall_hold%0d got %h req=%b exp %h req=0", i, out_vec(), ibus_if.ibus_req,
                                 {1'b1, 1'b0, 32'hBFC0_0008, 32'h3C01_0008});
      end
      if (i < 3) step();
    end
    step();
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_000C, 32'hAAAA_000C} || bus_vec() !== {1'b1, 32'hBFC0_0010}) begin
      tests_failed++; $display("FAIL stall_release got %h bus %h exp %h bus %h", out_vec(), bus_vec(),
                               {1'b1, 1'b0, 32'hBFC0_000C, 32'hAAAA_000C}, {1'b1, 32'hBFC0_0010});
    end
    $display("[TB] test_stall_hold done");
  endtask

  task automatic test_redirect_pending();
    redirect_en = 1'b1; redirect_pc = 32'h8000_0180;
    step();
    redirect_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (if_valid !== 1'b0 || bus_vec() !== {1'b1, 32'hBFC0_0010}) begin
        tests_failed++; $display("FAIL rdp_discard%0d got v=%b bus %h exp v=0 bus %h", i, if_valid, bus_vec(), {1'b1, 32'hBFC0_0010});
      end
      if (i == 1) drive(1'b1, 32'hDEAD_BEEF);
      step();
    end
    tests_run++;
    if (if_valid !== 1'b0 || bus_vec() !== {1'b1, 32'h8000_0180}) begin
      tests_failed++; $display("FAIL rdp_target got v=%b bus %h exp v=0 bus %h", if_valid, bus_vec(), {1'b1, 32'h8000_0180});
    end
    drive(1'b1, 32'h1111_0180);
    step();
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'h8000_0180, 32'h1111_0180} || bus_vec() !== {1'b1, 32'h8000_0184}) begin
      tests_failed++; $display("FAIL rdp_word got %h bus %h exp %h bus %h", out_vec(), bus_vec(),
                               {1'b1, 1'b0, 32'h8000_0180, 32'h1111_0180}, {1'b1, 32'h8000_0184});
    end
    $display("[TB] test_redirect_pending done");
  endtask

  task automatic test_redirect_ack();
    drive(1'b1, 32'hBAD0_0184);
    redirect_en = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_en = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0 || bus_vec() !== {1'b1, 32'h8000_0200}) begin
      tests_failed++; $display("FAIL rda_drop got v=%b bus %h exp v=0 bus %h", if_valid, bus_vec(), {1'b1, 32'h8000_0200});
    end
    $display("[TB] test_redirect_ack done");
  endtask

  task automatic test_adel();
    drive(1'b1, 32'hBAD0_0200);
    redirect_en = 1'b1; redirect_pc = 32'h0040_0002;
    step();
    redirect_en = 1'b0;
    drive(1'b0, 32'd0);
    tests_run++;
    if (ibus_if.ibus_req !== 1'b0 || if_valid !== 1'b0) begin
      tests_failed++; $display("FAIL adel_noreq got req=%b v=%b exp req=0 v=0", ibus_if.ibus_req, if_valid);
    end
    step();
    tests_run++;
    if (out_vec() !== {1'b1, 1'b1, 32'h0040_0002, 32'd0} || ibus_if.ibus_req !== 1'b0) begin
      tests_failed++; $display("FAIL adel_slot got %h req=%b exp %h req=0", out_vec(), ibus_if.ibus_req,
                               {1'b1, 1'b1, 32'h0040_0002, 32'd0});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (ibus_if.ibus_req !== 1'b0 || if_valid !== 1'b0) begin
        tests_failed++; $display("FAIL adel_halt%0d got req=%b v=%b exp req=0 v=0", i, ibus_if.ibus_req, if_valid);
      end
    end
    redirect_en = 1'b1; redirect_pc = 32'hBFC0_0380;
    step();
    redirect_en = 1'b0;
    tests_run++;
    if (bus_vec() !== {1'b1, 32'hBFC0_0380}) begin
      tests_failed++; $display("FAIL adel_resume got %h exp %h", bus_vec(), {1'b1, 32'hBFC0_0380});
    end
    drive(1'b1, 32'h2000_0380);
    step();
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_0380, 32'h2000_0380} || bus_vec() !== {1'b1, 32'hBFC0_0384}) begin
      tests_failed++; $display("FAIL adel_word got %h bus %h exp %h bus %h", out_vec(), bus_vec(),
                               {1'b1, 1'b0, 32'hBFC0_0380, 32'h2000_0380}, {1'b1, 32'hBFC0_0384});
    end
    $display("[TB] test_adel done");
  endtask

  task automatic test_reset_discard();
    drive(1'b0, 32'd0);
    redirect_en = 1'b1; redirect_pc = 32'h1234_5678;
    step();
    redirect_en = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0 || bus_vec() !== {1'b1, 32'hBFC0_0384}) begin
      tests_failed++; $display("FAIL rst_mid_discard got v=%b bus %h exp v=0 bus %h", if_valid, bus_vec(), {1'b1, 32'hBFC0_0384});
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_vec() !== 66'd0 || bus_vec() !== {1'b0, 32'hBFC0_0000}) begin
      tests_failed++; $display("FAIL rst_async got %h bus %h exp %h bus %h", out_vec(), bus_vec(), 66'd0, {1'b0, 32'hBFC0_0000});
    end
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (bus_vec() !== {1'b1, 32'hBFC0_0000}) begin
      tests_failed++; $display("FAIL rst_restart got %h exp %h", bus_vec(), {1'b1, 32'hBFC0_0000});
    end
    drive(1'b1, 32'h2408_0001);
    step();
    drive(1'b0, 32'd0);
    tests_run++;
    if (out_vec() !== {1'b1, 1'b0, 32'hBFC0_0000, 32'h2408_0001}) begin
      tests_failed++; $display("FAIL rst_first_word got %h exp %h", out_vec(), {1'b1, 1'b0, 32'hBFC0_0000, 32'h2408_0001});
    end
    $display("[TB] test_reset_discard done");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_delay();
    test_stall_hold();
    test_redirect_pending();
    test_redirect_ack();
    test_adel();
    test_reset_discard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
